// File: rtl/bit_serializer_if.sv
// Word intake and serial output bundle for bit_serializer.
// The master side supplies parallel words; the slave side is the serializer.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  ser_out,
    input  ser_valid,
    input  frame_start,
    input  busy
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output ser_out,
    output ser_valid,
    output frame_start,
    output busy
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: one WIDTH-bit word per frame, one bit per cycle.
// Define BIT_SERIALIZER_PREFETCH_EN to add a one-word holding buffer for gapless streams.
module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input logic             clk,
  input logic             reset,
  bit_serializer_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [4:0] LAST = 5'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             busy_q, busy_d;
  logic             data_ready;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] load_word;

`ifdef BIT_SERIALIZER_PREFETCH_EN
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  assign data_ready = reset && !hold_full_q;
`else
  assign data_ready = reset && (state_q == IDLE);
`endif

  assign accept = bus.data_valid && data_ready;

  // Bit idx of a frame (0 = first sent), honouring the configured bit order.
  function automatic logic bit_at(input logic [WIDTH-1:0] w, input logic [4:0] idx);
    logic [31:0] ext;
    logic [4:0]  pos;
    ext = 32'(w);
    pos = MSB_FIRST ? (LAST - idx) : idx;
    return ext[pos];
  endfunction

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shreg_d       = shreg_q;
    ser_out_d     = IDLE_LEVEL;
    ser_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    load          = 1'b0;
    load_word     = bus.data_in;
`ifdef BIT_SERIALIZER_PREFETCH_EN
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) load = 1'b1;
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
`ifdef BIT_SERIALIZER_PREFETCH_EN
          // A buffered word takes priority; an empty buffer lets a word
          // arriving on this edge bypass straight into the shift register.
          if (hold_full_q) begin
            load        = 1'b1;
            load_word   = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            load = 1'b1;
          end
`endif
          if (!load) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d       = cnt_q + 5'd1;
          ser_out_d   = bit_at(shreg_q, cnt_q + 5'd1);
          ser_valid_d = 1'b1;
`ifdef BIT_SERIALIZER_PREFETCH_EN
          if (accept) begin
            hold_d      = bus.data_in;
            hold_full_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d       = SHIFT;
      cnt_d         = '0;
      shreg_d       = load_word;
      ser_out_d     = bit_at(load_word, 5'd0);
      ser_valid_d   = 1'b1;
      frame_start_d = 1'b1;
    end

`ifdef BIT_SERIALIZER_PREFETCH_EN
    busy_d = (state_d == SHIFT) || hold_full_d;
`else
    busy_d = (state_d == SHIFT);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      shreg_q       <= '0;
      ser_out_q     <= IDLE_LEVEL;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shreg_q       <= shreg_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

`ifdef BIT_SERIALIZER_PREFETCH_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hold_full_q <= 1'b0;
    else        hold_full_q <= hold_full_d;
  end

  // NOTE: only the full flag is reset; the buffered data is ignored while
  // the flag is clear, so it needs no reset.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end
`endif

  assign bus.data_ready  = data_ready;
  assign bus.ser_out     = ser_out_q;
  assign bus.ser_valid   = ser_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = busy_q;

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, sets the parallel word width in bits (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1: 1 sends the MSB first, 0 sends the LSB first.
REQ-003 Parameter IDLE_LEVEL, default 0, is the value driven on ser_out when no bit is being sent.
REQ-004 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-006 Port data_in, input, WIDTH bits: parallel word to send.
REQ-007 Port data_valid, input, 1 bit: data_in holds a word.
REQ-008 Port data_ready, output, 1 bit: block can take a word this cycle.
REQ-009 Port ser_out, output, 1 bit: serial bit stream that feeds the downstream sequence detector "in" input.
REQ-010 Port ser_valid, output, 1 bit: ser_out carries a payload bit this cycle.
REQ-011 Port frame_start, output, 1 bit: one-cycle pulse that marks the first bit of each word.
REQ-012 Port busy, output, 1 bit: a word is being shifted or one is buffered.

Function
REQ-013 A word is accepted on a rising edge where data_valid=1 and data_ready=1; no other condition accepts a word.
REQ-014 The FSM has two states, IDLE and SHIFT, plus a 5-bit bit counter and a WIDTH-bit shift register.
REQ-015 IDLE -> SHIFT on an accept edge, which loads the shift register and clears the counter.
REQ-016 Latency: the first bit of a word appears on ser_out in the cycle right after its accept edge, with ser_valid=1 and frame_start=1.
REQ-017 Each bit is held for exactly one cycle; a word takes exactly WIDTH consecutive cycles; frame_start stays 0 on bits 2..WIDTH.
REQ-018 Bit order follows MSB_FIRST: data_in[WIDTH-1] first down to data_in[0], or the reverse when MSB_FIRST=0.
REQ-019 At the edge that ends bit WIDTH:
  - if a next word is available under the rules of REQ-028/029, it loads (SHIFT -> SHIFT);
  - otherwise the FSM goes SHIFT -> IDLE.
REQ-020 In IDLE: ser_out=IDLE_LEVEL, ser_valid=0, frame_start=0.
REQ-021 All outputs except data_ready are registered; data_ready is a combinational decode of state and buffer flags only, never of data_valid.
REQ-022 The shift register holds the word captured at accept; later changes on data_in do not affect a word in flight.
REQ-023 busy=1 whenever the state is SHIFT or the holding buffer is full; otherwise busy=0.
REQ-024 Counter wrap: the counter returns to 0 on every word load; it never exceeds WIDTH-1.

Reset
REQ-025 While reset=0, all of the following are forced asynchronously:
  - state=IDLE, counter=0, shift register=0, holding buffer empty;
  - ser_out=IDLE_LEVEL, ser_valid=0, frame_start=0, busy=0, data_ready=0.
REQ-026 Reset asserted mid-word aborts that word immediately; the remaining bits and any buffered word are discarded and never sent.
REQ-027 After reset is released (reset=1), data_ready=1 from the first clock cycle.

Configuration
REQ-028 Macro BIT_SERIALIZER_PREFETCH_EN defined:
  - a one-entry holding buffer is compiled in, and data_ready = buffer empty;
  - in IDLE with the buffer empty, an accepted word goes straight to the shift register;
  - during SHIFT, an accepted word fills the buffer;
  - at the edge ending bit WIDTH, a full buffer moves to the shift register, so the stream is gapless (no idle cycle between words).
REQ-029 Macro BIT_SERIALIZER_PREFETCH_EN not defined:
  - no holding buffer exists, and data_ready = (state == IDLE);
  - back-to-back words are therefore separated by exactly one IDLE cycle with ser_valid=0.

Verification
REQ-030 Basic word: WIDTH=8, MSB_FIRST=1, word 8'h55 accepted at edge E.
  - Required: ser_out = 0,1,0,1,0,1,0,1 in cycles E+1..E+8;
  - frame_start=1 only in E+1; ser_valid=0 and ser_out=0 in E+9.
REQ-031 LSB first: MSB_FIRST=0, word 8'hA0.
  - Required: ser_out = 0,0,0,0,0,1,0,1.
REQ-032 Back-to-back: data_valid held at 1 with words 8'hF0 then 8'h0F.
  - With the macro defined: 16 consecutive ser_valid=1 cycles, frame_start in cycles 1 and 9.
  - Without the macro: 8 valid cycles, 1 idle cycle, then 8 valid cycles.
REQ-033 Stall: data_valid=1 held with data_in changing while data_ready=0.
  - Required: no accept occurs; the bits in flight are unchanged; the captured word is the value present at the accept edge.
REQ-034 Reset mid-word: reset=0 asserted during bit 4 of 8'hFF, with the macro defined and the buffer full.
  - Required: ser_out=0 and ser_valid=0 at once, busy=0;
  - after release, no bits from the aborted or buffered word appear.
